draw_fade_overlay: RTL and testbench
====================================

// Module: draw_fade_overlay
// PURPOSE
//  VGA pipeline stage between draw_rect_char and the top-level output registers (vs/hs/{r,g,b}).
//  On game end it dims the whole frame to a floor brightness, frame by frame.
//  On restart it brightens the frame back to full.
//  Sync, blanking and counts pass through with the same latency as the RGB.
// PARAMETERS
//  FRAMES_PER_STEP  4   frames (vsync rising edges) per one brightness step, >=1
//  MIN_LEVEL        6   darkest fade level (0..15) so the end-screen text stays readable
// PORTS
//  pclk        in   1   pixel clock (40 MHz)
//  rst         in   1   asynchronous, active-low reset
//  hcount_in   in  11   horizontal count from upstream stage
//  hsync_in    in   1   horizontal sync
//  hblnk_in    in   1   horizontal blank
//  vcount_in   in  11   vertical count
//  vsync_in    in   1   vertical sync; its rising edge is the frame tick
//  vblnk_in    in   1   vertical blank
//  rgb_in      in  12   {r,g,b} 4 bits each
//  start       in   1   game running (level); requests fade-in
//  ending      in   1   game over (level); requests fade-out
//  hcount_out/hsync_out/hblnk_out/vcount_out/vsync_out/vblnk_out  out  as inputs  delayed 1 cycle
//  rgb_out     out 12   scaled RGB, delayed 1 cycle
//  fade_level  out  4   current level, 15 = full brightness
//  busy        out  1   1 while in FADE_OUT or FADE_IN
// BEHAVIOUR
//  - Reset (rst=0, async): all *_out=0, rgb_out=0, fade_level=15, busy=0, state BRIGHT, frame cnt=0, vsync_d=0.
//  - Latency: exactly 1 pclk for every output; all outputs are registered.
//  - Frame tick: vsync_in=1 & vsync_d=0, where vsync_d is vsync_in registered.
//  - Scaling per channel: c_out = (c_in * (L+1)) >> 4. The product is 4b x 5b = 9b; keep bits [7:4].
//    L=15 is identity; L=0 gives 0.
//  - rgb_out=0 whenever hblnk_in | vblnk_in, regardless of L.
//  - Level changes only on a frame tick. No mid-frame brightness change.
//  - FSM:
//     BRIGHT   L=15. ending -> FADE_OUT.
//     FADE_OUT start & !ending -> FADE_IN.
//              On each FRAMES_PER_STEP-th tick: L <= L-1.
//              When L reaches MIN_LEVEL -> DARK.
//     DARK     L=MIN_LEVEL held. start & !ending -> FADE_IN.
//     FADE_IN  ending -> FADE_OUT.
//              On each FRAMES_PER_STEP-th tick: L <= L+1.
//              When L reaches 15 -> BRIGHT.
//  - Priority: ending wins when start and ending are both 1.
//  - Frame counter clears on every state change. It counts ticks 0..FRAMES_PER_STEP-1 and steps L on the last one.
//  - Fade reversal keeps the current L; there is no jump.
//  - MIN_LEVEL>=15: FADE_OUT goes straight to DARK at L=15.
//  - Reset mid-fade returns to BRIGHT immediately.
// CONFIGURATION
//  FADE_TINT_EN defined:
//    red channel always passes unscaled; green/blue scale as above, giving a red game-over tint.
//    Blanking still forces 0.
//  FADE_TINT_EN undefined: all three channels scale identically.
// TESTING
//  1 Reset: rst=0 mid-frame with rgb_in=FFF -> rgb_out=000, fade_level=15, busy=0 asynchronously.
//    After rst=1, outputs follow inputs 1 cycle later.
//  2 Pass-through: BRIGHT, rgb_in=ABC, hblnk=vblnk=0 -> rgb_out=ABC 1 cycle later.
//    hsync/vsync/hcount/vcount delayed exactly 1 cycle.
//  3 Fade-out: ending=1, rgb_in=FFF.
//    After 4 ticks -> L=14, rgb_out=EEE.
//    After 36 ticks -> L=6, state DARK, busy=0, rgb_out=666 (with FADE_TINT_EN: F66).
//  4 Reversal: start=1 while FADE_OUT at L=10 -> busy stays 1.
//    L=11 after 4 more ticks; L=15 after 20 ticks, then BRIGHT.
//  5 Blanking: L=15, hblnk_in=1, rgb_in=FFF -> rgb_out=000. Same with vblnk_in=1.
//  6 Conflict: BRIGHT, start=ending=1 -> state FADE_OUT. L=14 after 4 ticks.

Source files
------------

// File: rtl/draw_fade_overlay.sv
// draw_fade_overlay
//   VGA pipeline stage that sits after draw_rect_char. When the game ends it
//   dims the frame one brightness step per FRAMES_PER_STEP frames, down to
//   MIN_LEVEL. When the game restarts it brightens the frame back to full.
//   Sync, blanking and counts are delayed by the same single register as RGB.
//
//   Optional build macro: FADE_TINT_EN -- red passes unscaled (red tint on fade).
//
// Ports
//   pclk, rst                  pixel clock, async active-low reset
//   hcount/hsync/hblnk_in      horizontal timing from upstream
//   vcount/vsync/vblnk_in      vertical timing; vsync rising edge = frame tick
//   rgb_in [11:0]              {r,g,b}, 4 bits each
//   start, ending              game running / game over levels (ending wins)
//   *_out                      timing delayed 1 pclk
//   rgb_out [11:0]             scaled RGB, delayed 1 pclk, 0 during blanking
//   fade_level [3:0]           current level, 15 = full brightness
//   busy                       1 while fading in either direction
module draw_fade_overlay #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int MIN_LEVEL       = 6
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        start,
    input  logic        ending,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [3:0]  fade_level,
    output logic        busy
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST  = CW'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]    MIN_L = (MIN_LEVEL >= 15) ? 4'd15 : 4'(MIN_LEVEL);

    typedef enum logic [1:0] {BRIGHT, FADE_OUT, DARK, FADE_IN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      lvl, lvl_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            vsync_d;
    logic            tick, step;
    logic            busy_nxt;
    logic [11:0]     rgb_nxt;

    // c * (L+1) is a 9-bit product; bits [7:4] give the dimmed channel.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
        logic [8:0] p;
        p = 9'(c) * 9'({1'b0, l} + 5'd1);
        return p[7:4];
    endfunction

    assign tick = vsync_in & ~vsync_d;
    assign step = tick && (cnt == LAST);

    // State register
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state   <= BRIGHT;
            lvl     <= 4'd15;
            cnt     <= '0;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            lvl     <= lvl_nxt;
            cnt     <= cnt_nxt;
            vsync_d <= vsync_in;
        end
    end

    // Next-state logic. Mode switches may happen on any cycle, but the level
    // itself only moves on a frame tick, so brightness never changes mid-frame.
    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl;
        cnt_nxt   = cnt;
        case (state)
            BRIGHT: if (ending) state_nxt = FADE_OUT;
            FADE_OUT: begin
                if (start && !ending)
                    state_nxt = FADE_IN;
                else if (lvl <= MIN_L)
                    state_nxt = DARK;      // covers MIN_LEVEL>=15 and reversal at floor
                else if (tick) begin
                    cnt_nxt = step ? '0 : cnt + CW'(1);
                    if (step) begin
                        lvl_nxt = lvl - 4'd1;
                        if (lvl_nxt <= MIN_L) state_nxt = DARK;
                    end
                end
            end
            DARK: if (start && !ending) state_nxt = FADE_IN;
            FADE_IN: begin
                if (ending)
                    state_nxt = FADE_OUT;
                else if (lvl == 4'd15)
                    state_nxt = BRIGHT;
                else if (tick) begin
                    cnt_nxt = step ? '0 : cnt + CW'(1);
                    if (step) begin
                        lvl_nxt = lvl + 4'd1;
                        if (lvl_nxt == 4'd15) state_nxt = BRIGHT;
                    end
                end
            end
            default: state_nxt = BRIGHT;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Output logic
    always_comb begin
        busy_nxt = (state_nxt == FADE_OUT) || (state_nxt == FADE_IN);
        rgb_nxt  = '0;
        if (!(hblnk_in || vblnk_in)) begin
`ifdef FADE_TINT_EN
            rgb_nxt[11:8] = rgb_in[11:8];
`else
            rgb_nxt[11:8] = scale(rgb_in[11:8], lvl);
`endif
            rgb_nxt[7:4]  = scale(rgb_in[7:4], lvl);
            rgb_nxt[3:0]  = scale(rgb_in[3:0], lvl);
        end
    end

    // Output register: every output carries exactly one pclk of latency.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            fade_level <= 4'd15;
            busy       <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vcount_out <= vcount_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_nxt;
            fade_level <= lvl_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_draw_fade_overlay.sv
module tb_draw_fade_overlay;

    localparam int FPS = 4;
    localparam int MINL = 6;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 0, hblnk_in = 0, vsync_in = 0, vblnk_in = 0;
    logic [11:0] rgb_in = '0;
    logic        start = 0, ending = 0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [3:0]  fade_level;
    logic        busy;

    int total = 0;
    int bad = 0;

    draw_fade_overlay #(.FRAMES_PER_STEP(FPS), .MIN_LEVEL(MINL)) dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .start(start), .ending(ending),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .fade_level(fade_level), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // Reference: each channel is the integer c*(L+1)/16; blanking forces black.
    function automatic logic [11:0] ref_rgb(input logic [11:0] c, input int l, input logic blank);
        int r, g, b;
        if (blank) return 12'h000;
`ifdef FADE_TINT_EN
        r = int'(c[11:8]);
`else
        r = (int'(c[11:8]) * (l + 1)) / 16;
`endif
        g = (int'(c[7:4]) * (l + 1)) / 16;
        b = (int'(c[3:0]) * (l + 1)) / 16;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    // Level after n ticks of fading, starting at l0, clamped to the range end.
    function automatic int lvl_out(input int l0, input int n);
        int l = l0 - n / FPS;
        return (l < MINL) ? MINL : l;
    endfunction
    function automatic int lvl_in(input int l0, input int n);
        int l = l0 + n / FPS;
        return (l > 15) ? 15 : l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    // One frame tick: vsync high for a cycle (inside vblank), then low again.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1; vblnk_in = 1;
            cyc();
            vsync_in = 0;
            cyc();
            vblnk_in = 0;
        end
    endtask

    // Random pixels/timing with no frame tick; checks the 1-cycle delayed outputs.
    task automatic rand_pix(input string tag, input int n, input int l);
        logic [37:0] tim;
        logic [11:0] c;
        logic        blank;
        for (int i = 0; i < n; i++) begin
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            hsync_in  = 1'($urandom);  vsync_in  = 1'b0;
            hblnk_in  = ($urandom_range(0, 3) == 0);
            vblnk_in  = ($urandom_range(0, 5) == 0);
            rgb_in    = 12'($urandom);
            tim   = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, 12'h0};
            c     = rgb_in;
            blank = hblnk_in | vblnk_in;
            cyc();
            chk({tag, "_timing"}, 32'({hcount_out, hsync_out, hblnk_out, vcount_out,
                                      vsync_out, vblnk_out, 12'h0} >> 12), 32'(tim >> 12));
            chk({tag, "_rgb"}, 32'(rgb_out), 32'(ref_rgb(c, l, blank)));
        end
        hblnk_in = 0; vblnk_in = 0; vsync_in = 0;
    endtask

    initial begin
        // 1 Reset and asynchronous re-assertion
        repeat (3) cyc();
        chk("rst_level", 32'(fade_level), 32'd15);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1; rgb_in = 12'hFFF;
        cyc(); cyc();
        chk("post_rst_rgb", 32'(rgb_out), 32'hFFF);
        #2 rst = 0;
        #1;
        chk("async_rst_rgb", 32'(rgb_out), 32'h000);
        chk("async_rst_level", 32'(fade_level), 32'd15);
        chk("async_rst_busy", 32'(busy), 32'd0);
        cyc();
        rst = 1;
        cyc();

        // 2 Pass-through at full brightness
        rgb_in = 12'hABC;
        cyc();
        chk("pass_ABC", 32'(rgb_out), 32'hABC);
        rand_pix("pass", 20, 15);

        // 3 Fade-out to the floor
        ending = 1; rgb_in = 12'hFFF;
        cyc();
        chk("fo_busy", 32'(busy), 32'd1);
        ticks(3);
        chk("fo_3ticks", 32'(fade_level), 32'(lvl_out(15, 3)));
        ticks(1);
        chk("fo_4ticks", 32'(fade_level), 32'(lvl_out(15, 4)));
        rgb_in = 12'hFFF;
        cyc();
        chk("fo_rgb_L14", 32'(rgb_out), 32'(ref_rgb(12'hFFF, 14, 1'b0)));
        ticks(32);
        chk("fo_36ticks", 32'(fade_level), 32'(lvl_out(15, 36)));
        chk("dark_busy", 32'(busy), 32'd0);
        rgb_in = 12'hFFF;
        cyc();
`ifdef FADE_TINT_EN
        chk("dark_rgb", 32'(rgb_out), 32'hF66);
`else
        chk("dark_rgb", 32'(rgb_out), 32'h666);
`endif
        ticks(8);
        chk("dark_hold", 32'(fade_level), 32'(MINL));
        rand_pix("dark", 20, MINL);

        // Reset during fade-in returns straight to full brightness
        ending = 0; start = 1;
        cyc();
        ticks(4);
        chk("fi_step", 32'(fade_level), 32'(lvl_in(MINL, 4)));
        chk("fi_busy", 32'(busy), 32'd1);
        #2 rst = 0;
        #1;
        chk("midfade_rst_level", 32'(fade_level), 32'd15);
        chk("midfade_rst_busy", 32'(busy), 32'd0);
        start = 0;
        cyc();
        rst = 1;
        cyc();

        // 4 Reversal at L=10
        ending = 1;
        cyc();
        ticks(20);
        chk("rev_L10", 32'(fade_level), 32'(lvl_out(15, 20)));
        ending = 0; start = 1;
        cyc();
        chk("rev_busy", 32'(busy), 32'd1);
        chk("rev_no_jump", 32'(fade_level), 32'd10);
        ticks(4);
        chk("rev_L11", 32'(fade_level), 32'(lvl_in(10, 4)));
        ticks(16);
        chk("rev_L15", 32'(fade_level), 32'(lvl_in(10, 20)));
        chk("rev_bright_busy", 32'(busy), 32'd0);
        start = 0;

        // 5 Blanking at full brightness
        rgb_in = 12'hFFF; hblnk_in = 1;
        cyc();
        chk("hblank_rgb", 32'(rgb_out), 32'h000);
        hblnk_in = 0; vblnk_in = 1;
        cyc();
        chk("vblank_rgb", 32'(rgb_out), 32'h000);
        vblnk_in = 0;

        // 6 Conflict: ending wins
        start = 1; ending = 1;
        cyc();
        chk("conf_busy", 32'(busy), 32'd1);
        ticks(3);
        chk("conf_3ticks", 32'(fade_level), 32'd15);
        ticks(1);
        chk("conf_L14", 32'(fade_level), 32'(lvl_out(15, 4)));
        rand_pix("conf", 10, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
